// File: rtl/axi_ram_responder.sv
// axi_ram_responder: single-port on-chip RAM slave on the meta AXI4 subset
// (AW/W/B/AR/R, no IDs, no strobes, incrementing bursts). One burst is
// served at a time; AW/AR contention is settled round-robin.
// Optional build macro AXI_RAM_STALL_EN: stall wready / R loads every 4th cycle.
module axi_ram_responder #(
  parameter int A_WIDTH    = 26,
  parameter int D_LEVEL    = 1,
  parameter int D_WIDTH    = (8 << D_LEVEL),
  parameter int MEM_A_BITS = 10
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               awvalid,
  output logic               awready,
  input  logic [A_WIDTH-1:0] awaddr,
  input  logic [7:0]         awlen,
  input  logic               wvalid,
  output logic               wready,
  input  logic               wlast,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               bvalid,
  input  logic               bready,
  input  logic               arvalid,
  output logic               arready,
  input  logic [A_WIDTH-1:0] araddr,
  input  logic [7:0]         arlen,
  output logic               rvalid,
  input  logic               rready,
  output logic               rlast,
  output logic [D_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << MEM_A_BITS;
  localparam logic [MEM_A_BITS-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WRESP,
    READ
  } state_t;

  state_t                state;
  logic                  rr;
  logic [MEM_A_BITS-1:0] idx;
  logic [7:0]            cnt;
  logic                  stall;
  logic                  wbeat;
  logic [MEM_A_BITS-1:0] aw_idx;
  logic [MEM_A_BITS-1:0] ar_idx;

  logic [D_WIDTH-1:0] mem [0:DEPTH-1];

  // wlast and the address bits outside the word index are intentionally ignored
  logic unused_inputs;
  assign unused_inputs = ^{wlast, awaddr, araddr};

  assign aw_idx = awaddr[D_LEVEL +: MEM_A_BITS];
  assign ar_idx = araddr[D_LEVEL +: MEM_A_BITS];

`ifdef AXI_RAM_STALL_EN
  logic [1:0] stall_cnt;

  // Free-running phase counter for the periodic backpressure stall
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 2'd1;
    end
  end

  assign stall = (stall_cnt == 2'd3);
`else
  assign stall = 1'b0;
`endif

  assign wready = (state == WRITE) && !stall;
  assign wbeat  = wvalid && wready;

  // Address-channel grant in IDLE; rr breaks the tie when both are requesting
  always_comb begin
    awready = 1'b0;
    arready = 1'b0;
    if (state == IDLE) begin
      if (awvalid && (!arvalid || !rr)) awready = 1'b1;
      if (arvalid && (!awvalid || rr))  arready = 1'b1;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge aclk) begin
    if (wbeat) mem[idx] <= wdata;
  end

  // Burst sequencer and registered B/R outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      rr     <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (awready) begin
            idx   <= aw_idx;
            cnt   <= awlen;
            rr    <= ~rr;
            state <= WRITE;
          end else if (arready) begin
            // The first beat is loaded on the grant edge so rvalid rises in
            // the cycle right after the AR handshake; cnt then holds the
            // number of beats still to be loaded.
            rdata  <= mem[ar_idx];
            rvalid <= 1'b1;
            rlast  <= (arlen == 8'd0);
            idx    <= ar_idx + IDX_ONE;
            cnt    <= arlen;
            rr     <= ~rr;
            state  <= READ;
          end
        end
        WRITE: begin
          if (wbeat) begin
            idx <= idx + IDX_ONE;
            if (cnt == 8'd0) begin
              bvalid <= 1'b1;
              state  <= WRESP;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        WRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        READ: begin
          if (rvalid && rready && rlast) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            state  <= IDLE;
          end else if (!rvalid || rready) begin
            // Beats always remain here: the final beat carries rlast.
            if (!stall) begin
              rdata  <= mem[idx];
              rvalid <= 1'b1;
              rlast  <= (cnt == 8'd1);
              idx    <= idx + IDX_ONE;
              cnt    <= cnt - 8'd1;
            end else begin
              rvalid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Self-checking bench for axi_ram_responder (default parameters, no stalls).
module tb_axi_ram_responder;

  logic        aclk;
  logic        areset;
  logic        awvalid;
  logic        awready;
  logic [25:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic [15:0] wdata;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [25:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic [15:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word-addressed RAM image plus a written map
  logic [15:0] model_mem [0:1023];
  bit          written   [0:1023];
  logic [15:0] wbuf      [0:255];

  axi_ram_responder #(
    .A_WIDTH(26),
    .D_LEVEL(1),
    .D_WIDTH(16),
    .MEM_A_BITS(10)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .awvalid(awvalid),
    .awready(awready),
    .awaddr(awaddr),
    .awlen(awlen),
    .wvalid(wvalid),
    .wready(wready),
    .wlast(wlast),
    .wdata(wdata),
    .bvalid(bvalid),
    .bready(bready),
    .arvalid(arvalid),
    .arready(arready),
    .araddr(araddr),
    .arlen(arlen),
    .rvalid(rvalid),
    .rready(rready),
    .rlast(rlast),
    .rdata(rdata)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_d(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [25:0] a);
    return (int'(a) / 2) % 1024;
  endfunction

  // Write burst of l+1 beats from wbuf; hold = cycles to keep bready low
  task automatic write_burst(input logic [25:0] a, input int l, input int hold);
    int w0;
    w0 = word_of(a);
    awaddr  = a;
    awlen   = 8'(l);
    awvalid = 1'b1;
    #1;
    for (int n = 0; n < 50 && !awready; n++) begin
      @(posedge aclk); #2;
    end
    chk_b("aw_ready", awready, 1'b1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= l; i++) begin
      wvalid = 1'b1;
      wdata  = wbuf[i];
      wlast  = (i == l);
      #1;
      for (int n = 0; n < 50 && !wready; n++) begin
        @(posedge aclk); #2;
      end
      chk_b("w_ready", wready, 1'b1);
      @(posedge aclk); #1;
      model_mem[(w0 + i) % 1024] = wbuf[i];
      written[(w0 + i) % 1024]   = 1'b1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk_b("b_valid_after_last", bvalid, 1'b1);
    if (hold > 0) awvalid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      chk_b("b_held", bvalid, 1'b1);
      chk_b("aw_blocked_in_wresp", awready, 1'b0);
      @(posedge aclk); #1;
    end
    bready = 1'b1;
    #1;
    for (int n = 0; n < 50 && !bvalid; n++) begin
      @(posedge aclk); #2;
    end
    chk_b("b_valid", bvalid, 1'b1);
    @(posedge aclk); #1;
    bready = 1'b0;
    chk_b("b_cleared", bvalid, 1'b0);
    if (hold > 0) begin
      chk_b("aw_ready_after_b", awready, 1'b1);
      #1;
      awvalid = 1'b0;
    end
  endtask

  // Read burst of l+1 beats; mode 0: rready high, 1: 1,0,0 pattern, 2: random
  task automatic read_burst(input logic [25:0] a, input int l, input int mode,
                            output logic [15:0] last_d);
    int          r0;
    int          beat;
    int          cyc;
    bit          stalled;
    logic [15:0] pd;
    logic        pl;
    r0      = word_of(a);
    last_d  = '0;
    araddr  = a;
    arlen   = 8'(l);
    arvalid = 1'b1;
    #1;
    for (int n = 0; n < 50 && !arready; n++) begin
      @(posedge aclk); #2;
    end
    chk_b("ar_ready", arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    chk_b("r_first_valid", rvalid, 1'b1);
    beat    = 0;
    cyc     = 0;
    stalled = 1'b0;
    pd      = '0;
    pl      = 1'b0;
    while (beat <= l && cyc < 2000) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = ((cyc % 3) == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stalled) begin
        chk_b("r_hold_valid", rvalid, 1'b1);
        chk_d("r_hold_data", rdata, pd);
        chk_b("r_hold_last", rlast, pl);
      end
      if (mode == 0) chk_b("r_throughput", rvalid, 1'b1);
      if (rvalid && rready) begin
        if (written[(r0 + beat) % 1024]) chk_d("r_data", rdata, model_mem[(r0 + beat) % 1024]);
        chk_b("r_last", rlast, (beat == l));
        last_d = rdata;
        beat++;
      end
      stalled = rvalid && !rready;
      pd      = rdata;
      pl      = rlast;
      @(posedge aclk); #1;
      cyc++;
    end
    rready = 1'b0;
    if (beat <= l) chk_b("r_burst_timeout", rvalid && rlast, 1'b1);
    chk_b("r_done", rvalid, 1'b0);
  endtask

  typedef struct {
    bit          wr;
    logic [25:0] waddr;
    int          wlen;
    logic [15:0] base;
    logic [15:0] step;
    logic [25:0] raddr;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] got;
  logic [25:0] ra;
  logic [25:0] wa;
  int          wl;
  int          rl;

  initial begin
    vecs[0] = '{1'b1, 26'h0000000, 3, 16'h1111, 16'h1111, 26'h0000006, 16'h4444};
    vecs[1] = '{1'b1, 26'h00007FE, 1, 16'hAAAA, 16'h1111, 26'h0000000, 16'hBBBB};
    vecs[2] = '{1'b0, 26'h0000000, 0, 16'h0000, 16'h0000, 26'h20007FE, 16'hAAAA};
    vecs[3] = '{1'b0, 26'h0000000, 0, 16'h0000, 16'h0000, 26'h3FFFFFF, 16'hAAAA};
    vecs[4] = '{1'b1, 26'h0000100, 0, 16'h5A5A, 16'h0000, 26'h0000101, 16'h5A5A};
    vecs[5] = '{1'b1, 26'h00037FC, 2, 16'h0101, 16'h0101, 26'h0000000, 16'h0303};
    vecs[6] = '{1'b0, 26'h0000000, 0, 16'h0000, 16'h0000, 26'h0000004, 16'h3333};
    vecs[7] = '{1'b0, 26'h0000000, 0, 16'h0000, 16'h0000, 26'h00007FE, 16'h0202};

    for (int i = 0; i < 1024; i++) written[i] = 1'b0;

    areset  = 1'b1;
    awvalid = 1'b0;
    awaddr  = '0;
    awlen   = '0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    wdata   = '0;
    bready  = 1'b0;
    arvalid = 1'b0;
    araddr  = '0;
    arlen   = '0;
    rready  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk_b("rst_awready", awready, 1'b0);
    chk_b("rst_wready", wready, 1'b0);
    chk_b("rst_bvalid", bvalid, 1'b0);
    chk_b("rst_arready", arready, 1'b0);
    chk_b("rst_rvalid", rvalid, 1'b0);
    chk_b("rst_rlast", rlast, 1'b0);
    chk_d("rst_rdata", rdata, 16'h0000);
    areset = 1'b0;
    @(posedge aclk); #1;

    // Round-robin from reset: W, R, W, R
    for (int k = 0; k < 2; k++) begin
      wa      = 26'h200 + 26'(2 * k);
      awaddr  = wa;
      awlen   = 8'd0;
      araddr  = wa;
      arlen   = 8'd0;
      awvalid = 1'b1;
      arvalid = 1'b1;
      #1;
      chk_b("arb_aw_first", awready, 1'b1);
      chk_b("arb_ar_waits", arready, 1'b0);
      wbuf[0] = (k == 0) ? 16'hC0DE : 16'hBEEF;
      write_burst(wa, 0, 0);
      #1;
      chk_b("arb_ar_second", arready, 1'b1);
      read_burst(wa, 0, 0, got);
      chk_d("arb_readback", got, wbuf[0]);
    end

    // Basic 4-beat write then read-back
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    write_burst(26'h000, 3, 0);
    read_burst(26'h000, 3, 0, got);
    chk_d("basic_last_word", got, 16'h4444);

    // Backpressure on an 8-beat read
    for (int i = 0; i < 8; i++) wbuf[i] = 16'hD000 + 16'(i);
    write_burst(26'h040, 7, 0);
    read_burst(26'h040, 7, 1, got);
    chk_d("bp_last_word", got, 16'hD007);

    // Write response held off for 5 cycles
    wbuf[0] = 16'h7777;
    write_burst(26'h080, 0, 5);

    // Reset during beat 3 of an 8-beat read
    araddr  = 26'h040;
    arlen   = 8'd7;
    arvalid = 1'b1;
    #1;
    chk_b("rst_mid_ar", arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    repeat (2) begin
      @(posedge aclk); #1;
    end
    chk_d("rst_mid_beat3", rdata, 16'hD002);
    areset = 1'b1;
    #1;
    chk_b("rst_mid_rvalid", rvalid, 1'b0);
    chk_b("rst_mid_rlast", rlast, 1'b0);
    @(posedge aclk); #1;
    chk_b("rst_mid_rvalid_edge", rvalid, 1'b0);
    areset = 1'b0;
    rready = 1'b0;
    @(posedge aclk); #1;
    arvalid = 1'b1;
    araddr  = 26'h040;
    #1;
    chk_b("rst_mid_idle", arready, 1'b1);
    arvalid = 1'b0;
    read_burst(26'h040, 7, 0, got);
    chk_d("rst_mid_intact", got, 16'hD007);

    // Table-driven alias / wrap vectors
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].wr) begin
        for (int i = 0; i <= vecs[v].wlen; i++)
          wbuf[i] = vecs[v].base + 16'(i) * vecs[v].step;
        write_burst(vecs[v].waddr, vecs[v].wlen, 0);
      end
      read_burst(vecs[v].raddr, 0, 0, got);
      chk_d("vec_readback", got, vecs[v].exp);
    end

    // Randomized bursts against the model; first one is a 256-beat burst
    for (int k = 0; k < 30; k++) begin
      wa = 26'($urandom());
      wl = (k == 0) ? 255 : int'($urandom_range(0, 15));
      for (int i = 0; i <= wl; i++) wbuf[i] = 16'($urandom());
      write_burst(wa, wl, int'($urandom_range(0, 2)));
      if (k == 0) begin
        ra = wa;
        rl = 255;
      end else begin
        ra = wa + 26'(2 * $urandom_range(0, 8));
        rl = int'($urandom_range(0, 15));
      end
      read_burst(ra, rl, 2, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
